// File: rtl/fetch_unit_if.sv
`timescale 1ns/1ps
// Bundle of the fetch unit's memory, redirect and decode-side signals.
// The master side is the fetch unit; the slave side is memory, execute and decode.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic            redirect_jalr;
    logic [XLEN-1:0] redirect_base;
    logic [XLEN-1:0] redirect_offset;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;
    logic            fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_jalr, redirect_base, redirect_offset,
        output out_valid, out_instr, out_pc, out_pc_plus4, fetch_fault,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_jalr, redirect_base, redirect_offset,
        input  out_valid, out_instr, out_pc, out_pc_plus4, fetch_fault,
        output out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Pipelined instruction fetch: owns the fetch PC, issues credit-limited in-order
// imem requests, buffers returned words in a FIFO and applies execute redirects.
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              DEPTH        = 4
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);

    logic [1:0]      state;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   fifo_count;
    logic [AW-1:0]   fifo_rd;
    logic [AW-1:0]   fifo_wr;
    logic [AW-1:0]   tag_rd;
    logic [AW-1:0]   tag_wr;

    logic [31:0]     fifo_instr [DEPTH];
    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic [XLEN-1:0] fifo_pc4   [DEPTH];
    logic [XLEN-1:0] tag_pc     [DEPTH];

    logic [XLEN-1:0] target_sum;
    logic [XLEN-1:0] target;
    logic            target_misaligned;
    logic [CW:0]     credit_sum;
    logic            req_fire;
    logic            rsp_fire;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [CW-1:0]   inflight_next;
    logic [XLEN-1:0] rsp_pc;

    // JALR drops bit 0 of the sum; any remaining low bit set means a misaligned target.
    assign target_sum        = bus.redirect_base + bus.redirect_offset;
    assign target            = bus.redirect_jalr ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
    assign target_misaligned = (target[1:0] != 2'b00);

    // Every request holds a FIFO slot until popped, so the FIFO can never overflow.
    assign credit_sum     = {1'b0, fifo_count} + {1'b0, inflight};
    assign bus.imem_req_valid = (state == ST_RUN) && (credit_sum < CREDITS);
    assign bus.imem_req_addr  = fetch_pc;

    assign req_fire      = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_fire      = bus.imem_rsp_valid && (inflight != '0);
    assign push          = rsp_fire && (drop == '0) && !bus.redirect_valid;
    assign head_valid    = (fifo_count != '0);
    assign pop           = head_valid && bus.out_ready && !bus.redirect_valid;
    assign inflight_next = inflight + CW'(req_fire) - CW'(rsp_fire);
    assign rsp_pc        = tag_pc[tag_rd];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            fetch_pc   <= RESET_VECTOR;
            inflight   <= '0;
            drop       <= '0;
            fifo_count <= '0;
            fifo_rd    <= '0;
            fifo_wr    <= '0;
            tag_rd     <= '0;
            tag_wr     <= '0;
        end else begin
            inflight <= inflight_next;
            // The tag queue tracks every outstanding request, wrong-path ones included.
            if (req_fire) tag_wr <= tag_wr + 1'b1;
            if (rsp_fire) tag_rd <= tag_rd + 1'b1;

            if (bus.redirect_valid) begin
                fetch_pc   <= target;
                drop       <= inflight_next;
                fifo_count <= '0;
                fifo_rd    <= '0;
                fifo_wr    <= '0;
                state      <= target_misaligned ? ST_FAULT : ST_RUN;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
                if (rsp_fire && (drop != '0)) drop <= drop - 1'b1;
                if (push) fifo_wr <= fifo_wr + 1'b1;
                if (pop)  fifo_rd <= fifo_rd + 1'b1;
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
                if (state == ST_IDLE) state <= ST_RUN;
            end
        end
    end

    // NOTE: storage arrays carry no reset; the outputs are gated by head_valid, so stale
    // contents are never observable and the arrays stay plain RAM-style registers.
    always_ff @(posedge clk) begin
        if (req_fire) tag_pc[tag_wr] <= fetch_pc;
        if (push) begin
            fifo_instr[fifo_wr] <= bus.imem_rsp_data;
            fifo_pc[fifo_wr]    <= rsp_pc;
            fifo_pc4[fifo_wr]   <= rsp_pc + PC_STEP;
        end
    end

    assign bus.out_valid    = head_valid;
    assign bus.out_instr    = head_valid ? fifo_instr[fifo_rd] : '0;
    assign bus.out_pc       = head_valid ? fifo_pc[fifo_rd]    : '0;
    assign bus.out_pc_plus4 = head_valid ? fifo_pc4[fifo_rd]   : '0;
    assign bus.fetch_fault  = (state == ST_FAULT);
endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Directed bench for fetch_unit: a latency-configurable in-order memory model, request
// and output logs, a redirect vector table and hand-written reset/stall/flush sequences.
module tb_fetch_unit;
    typedef struct { logic [31:0] addr; int cyc; } req_rec_t;
    typedef struct { logic [31:0] pc; logic [31:0] pc4; logic [31:0] instr; int cyc; } out_rec_t;
    typedef struct { logic [31:0] addr; int due; } mem_rec_t;
    typedef struct {
        logic        jalr;
        logic [31:0] base;
        logic [31:0] offset;
        logic [31:0] exp_target;
        logic        exp_fault;
    } redir_vec_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    int   lat;
    bit   mem_on;

    req_rec_t req_log[$];
    out_rec_t got[$];
    mem_rec_t memq[$];

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] req_addr(input int i);
        return (i < req_log.size()) ? req_log[i].addr : 32'hDEAD_BEEF;
    endfunction
    function automatic int req_cyc(input int i);
        return (i < req_log.size()) ? req_log[i].cyc : -100;
    endfunction
    function automatic logic [31:0] got_pc(input int i);
        return (i < got.size()) ? got[i].pc : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] got_pc4(input int i);
        return (i < got.size()) ? got[i].pc4 : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] got_instr(input int i);
        return (i < got.size()) ? got[i].instr : 32'hDEAD_BEEF;
    endfunction
    function automatic int got_cyc(input int i);
        return (i < got.size()) ? got[i].cyc : -100;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_fault"}, 32'(bus.fetch_fault), 32'd0);
        check({tag, "_req_addr"}, bus.imem_req_addr, 32'h0);
        check({tag, "_out_instr"}, bus.out_instr, 32'h0);
        check({tag, "_out_pc"}, bus.out_pc, 32'h0);
        check({tag, "_out_pc4"}, bus.out_pc_plus4, 32'h0);
    endtask

    // Memory model: in-order, one response per accepted request, lat cycles later.
    initial begin : mem_model
        logic        fire;
        logic        taken;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            fire  = bus.imem_req_valid && bus.imem_req_ready;
            a     = bus.imem_req_addr;
            taken = bus.imem_rsp_valid;
            @(posedge clk);
            #2;
            if (mem_on) begin
                if (taken && memq.size() > 0) void'(memq.pop_front());
                if (fire) memq.push_back('{addr: a, due: cyc + lat - 1});
                if (memq.size() > 0 && cyc >= memq[0].due) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = instr_of(memq[0].addr);
                end else begin
                    bus.imem_rsp_valid = 1'b0;
                    bus.imem_rsp_data  = 32'h0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.imem_req_valid && bus.imem_req_ready)
            req_log.push_back('{addr: bus.imem_req_addr, cyc: cyc});
        if (bus.out_valid && bus.out_ready)
            got.push_back('{pc: bus.out_pc, pc4: bus.out_pc_plus4, instr: bus.out_instr, cyc: cyc});
    end

    task automatic do_reset(input int cycles);
        mem_on             = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        reset              = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        memq.delete();
        req_log.delete();
        got.delete();
        reset  = 1'b1;
        mem_on = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : main
        redir_vec_t vecs[9];
        logic       all_ok;

        vecs[0] = '{1'b1, 32'h0000_0101, 32'h0000_0003, 32'h0000_0104, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0100, 32'h0000_0002, 32'h0000_0102, 1'b1};
        vecs[2] = '{1'b0, 32'h0000_0200, 32'h0000_0000, 32'h0000_0200, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0100, 32'h0000_0001, 32'h0000_0101, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_0000, 32'h0000_0203, 32'h0000_0202, 1'b1};
        vecs[5] = '{1'b0, 32'hFFFF_FFF0, 32'h0000_0014, 32'h0000_0004, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_0FFC, 1'b0};
        vecs[7] = '{1'b0, 32'hFFFF_FFF8, 32'h0000_0004, 32'hFFFF_FFFC, 1'b0};
        vecs[8] = '{1'b1, 32'h0000_0041, 32'h0000_0000, 32'h0000_0040, 1'b0};

        total = 0;
        bad   = 0;
        cyc   = 0;
        lat   = 1;
        mem_on = 1'b0;
        reset  = 1'b0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = 32'h0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_jalr   = 1'b0;
        bus.redirect_base   = 32'h0;
        bus.redirect_offset = 32'h0;
        bus.out_ready       = 1'b1;

        // Reset values, then sequential streaming with a 1-cycle memory.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        do_reset(1);
        wait_cycles(10);
        check("a_first_addr", req_addr(0), 32'h0);
        check("a_pc0", got_pc(0), 32'h0);
        check("a_pc1", got_pc(1), 32'h4);
        check("a_pc2", got_pc(2), 32'h8);
        check("a_pc4_0", got_pc4(0), 32'h4);
        check("a_pc4_1", got_pc4(1), 32'h8);
        check("a_pc4_2", got_pc4(2), 32'hC);
        check("a_instr1", got_instr(1), instr_of(32'h4));
        check("a_back2back", 32'(got_cyc(2) - got_cyc(0)), 32'd2);
        check("a_latency", 32'(got_cyc(0) - req_cyc(0)), 32'd2);

        // Decode stalled: exactly DEPTH requests, then resume in order.
        bus.out_ready = 1'b0;
        do_reset(2);
        wait_cycles(12);
        check("b_req_count", 32'(req_log.size()), 32'd4);
        check("b_req3", req_addr(3), 32'hC);
        check("b_req_valid_low", 32'(bus.imem_req_valid), 32'd0);
        check("b_head_pc", bus.out_pc, 32'h0);
        bus.out_ready = 1'b1;
        wait_cycles(10);
        check("b_pop0", got_pc(0), 32'h0);
        check("b_pop3", got_pc(3), 32'hC);
        check("b_pop4", got_pc(4), 32'h10);
        check("b_resume_addr", req_addr(4), 32'h10);
        check("b_pop_rate", 32'(got_cyc(3) - got_cyc(0)), 32'd3);

        // Branch redirect with three requests in flight on a slow memory.
        lat = 6;
        do_reset(2);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (req_log.size() >= 3) break;
        end
        bus.imem_req_ready = 1'b0;
        check("c_inflight", 32'(req_log.size()), 32'd3);
        bus.redirect_valid  = 1'b1;
        bus.redirect_jalr   = 1'b0;
        bus.redirect_base   = 32'h8;
        bus.redirect_offset = 32'h20;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        req_log.delete();
        got.delete();
        wait_cycles(25);
        check("c_next_req", req_addr(0), 32'h28);
        check("c_first_out", got_pc(0), 32'h28);
        check("c_first_instr", got_instr(0), instr_of(32'h28));
        check("c_second_out", got_pc(1), 32'h2C);
        all_ok = 1'b1;
        foreach (got[i]) if (got[i].instr !== instr_of(got[i].pc)) all_ok = 1'b0;
        check("c_instr_pairing", 32'(all_ok), 32'd1);

        // Redirect target table on a streaming 1-cycle memory.
        lat = 1;
        for (int v = 0; v < 9; v++) begin
            wait_cycles(3);
            bus.redirect_valid  = 1'b1;
            bus.redirect_jalr   = vecs[v].jalr;
            bus.redirect_base   = vecs[v].base;
            bus.redirect_offset = vecs[v].offset;
            @(posedge clk);
            #1;
            bus.redirect_valid = 1'b0;
            req_log.delete();
            got.delete();
            check($sformatf("v%0d_fault", v), 32'(bus.fetch_fault), 32'(vecs[v].exp_fault));
            check($sformatf("v%0d_flush", v), 32'(bus.out_valid), 32'd0);
            wait_cycles(6);
            if (vecs[v].exp_fault) begin
                check($sformatf("v%0d_no_req", v), 32'(req_log.size()), 32'd0);
                check($sformatf("v%0d_no_out", v), 32'(got.size()), 32'd0);
                check($sformatf("v%0d_req_valid", v), 32'(bus.imem_req_valid), 32'd0);
                check($sformatf("v%0d_fault_held", v), 32'(bus.fetch_fault), 32'd1);
            end else begin
                check($sformatf("v%0d_req", v), req_addr(0), vecs[v].exp_target);
                check($sformatf("v%0d_pc", v), got_pc(0), vecs[v].exp_target);
                check($sformatf("v%0d_pc4", v), got_pc4(0), vecs[v].exp_target + 32'd4);
                check($sformatf("v%0d_instr", v), got_instr(0), instr_of(vecs[v].exp_target));
            end
        end

        // Reset mid-stream with responses pending; responses during reset are ignored.
        lat = 3;
        wait_cycles(8);
        mem_on = 1'b0;
        reset  = 1'b0;
        #1;
        check_reset_outputs("mid");
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hBAD0_BAD0;
        wait_cycles(2);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        lat = 1;
        do_reset(1);
        wait_cycles(10);
        check("e_restart_addr", req_addr(0), 32'h0);
        check("e_first_pc", got_pc(0), 32'h0);
        check("e_first_instr", got_instr(0), instr_of(32'h0));
        check("e_second_pc", got_pc(1), 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised, pipelined successor to the single-cycle PC path (PC register, PC+4 adder, branch-target adder, branch/JALR muxes).
- Owns the fetch PC and issues requests to an instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions with their PC/PC+4 in a DEPTH-entry FIFO and presents them to decode over a valid/ready handshake.
- Accepts redirects (branch/JAL/JALR) from execute, discards wrong-path instructions, and detects misaligned targets.

Parameters:
- XLEN, 32, width of PC and address paths
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, FIFO entries and max in-flight requests (power of two, >=2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (word aligned)
- imem_rsp_valid  in  1  response valid; one per accepted request, in order, >=1 cycle after acceptance, no backpressure
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  one-cycle redirect strobe from execute
- redirect_jalr  in  1  1 = JALR target, 0 = branch/JAL target
- redirect_base  in  XLEN  PC of redirecting instr (branch/JAL) or rs1 (JALR)
- redirect_offset  in  XLEN  sign-extended immediate
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts (0 = stall)
- out_instr  out  32  instruction word
- out_pc  out  XLEN  PC of out_instr
- out_pc_plus4  out  XLEN  out_pc + 4 (mod 2^XLEN)
- fetch_fault  out  1  misaligned redirect target; fetch halted

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_VECTOR, FIFO empty, inflight=0, drop=0, state=IDLE; imem_req_valid=0, out_valid=0, fetch_fault=0, imem_req_addr=RESET_VECTOR, out_instr/out_pc/out_pc_plus4=0.
- FSM: IDLE -> RUN on first clock after reset deasserts. RUN -> FAULT on redirect with misaligned target. FAULT -> RUN on redirect with aligned target. Redirect in IDLE is applied and state moves to RUN.
- Target: sum = redirect_base + redirect_offset (mod 2^XLEN); JALR clears bit0 (sum & ~1); branch/JAL uses sum unchanged. Misaligned iff target[1:0] != 0, or bit0 set on a non-JALR target.
- Issue (RUN only): imem_req_valid = (fifo_count + inflight) < DEPTH; imem_req_addr = fetch_pc. On handshake fetch_pc += 4 (wraps), inflight += 1.
- Response: inflight -= 1. If drop>0, discard and drop -= 1; else push {data, pc, pc+4} to FIFO. The push PC comes from an internal in-order PC tag queue. The credit rule guarantees no overflow.
- Output: out_* reflect FIFO head, combinationally from registered storage. Pop on out_valid & out_ready. Push and pop in the same cycle are legal at any occupancy.
- Redirect has priority over issue, push, and pop in its cycle.
  - FIFO flushed; fetch_pc = target; drop = inflight after this cycle's response/acceptance accounting. A request accepted in the redirect cycle is counted as wrong-path.
  - out_valid=0 the cycle after. An out handshake coinciding with the redirect still counts as consumed.
- Misaligned target: state=FAULT, fetch_fault=1 (registered, next cycle). No new requests; outstanding responses are still drained and discarded; out_valid=0.
- Latency: request accepted at cycle N, response at N+k (k>=1) -> out_valid at N+k+1.
- Sequential throughput of 1 instr/cycle with zero-wait memory and out_ready=1.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle response latency -> first imem_req_addr=RESET_VECTOR; out_pc 0x0,0x4,0x8 on consecutive cycles; out_pc_plus4 0x4,0x8,0xC.
- out_ready=0 held, DEPTH=4 -> exactly 4 requests (0x0..0xC) accepted, then imem_req_valid=0. Release -> pops in order, issue resumes at 0x10.
- Branch redirect base=0x8, offset=0x20 with 3 requests in flight -> 3 responses discarded, next request 0x28, next out_pc=0x28, no stale instr visible.
- JALR redirect base=0x101, offset=0x3 -> target 0x104; fetch resumes at 0x104, fetch_fault=0.
- JALR base=0x100, offset=0x2 -> target 0x102: fetch_fault=1, no requests. Then redirect to 0x200 -> fault clears, fetch from 0x200.
- reset pulsed low mid-stream with responses pending -> all outputs at reset values immediately. After release, fetch restarts at RESET_VECTOR; late responses before release are ignored.
